// File: rtl/goofy_loader_if.sv
// rtl/goofy_loader_if.sv - byte-stream, control and RAM-port bundle of the goofy_loader program loader.
interface goofy_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        load_req;
  logic        ram_save;
  logic [7:0]  ram_in;
  logic [15:0] ram_addr;
  logic        ram_own;
  logic        core_res;
  logic        done;
  logic        err;

  modport master (
    output in_valid, in_data, load_req,
    input  in_ready, ram_save, ram_in, ram_addr, ram_own, core_res, done, err
  );

  modport slave (
    input  in_valid, in_data, load_req,
    output in_ready, ram_save, ram_in, ram_addr, ram_own, core_res, done, err
  );
endinterface

// File: rtl/goofy_loader.sv
// rtl/goofy_loader.sv - framed byte-stream program loader that writes GoofyRam and holds the core in reset.
module goofy_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter logic [15:0] MAX_LEN   = 16'h8000
) (
  input logic           clk,
  input logic           res,
  goofy_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_RUN, S_ERROR
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  sum_q, sum_d;
  logic        ram_save_q, ram_save_d;
  logic [7:0]  ram_in_q, ram_in_d;
  logic [15:0] ram_addr_q, ram_addr_d;
  logic        ram_own_q, ram_own_d;
  logic        core_res_q, core_res_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        xfer;
  logic [15:0] full_len;

  assign bus.in_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                        (state_q == S_DATA)   || (state_q == S_CSUM);
  assign xfer     = bus.in_valid && bus.in_ready;
  assign full_len = {len_q[15:8], bus.in_data};

  assign bus.ram_save = ram_save_q;
  assign bus.ram_in   = ram_in_q;
  assign bus.ram_addr = ram_addr_q;
  assign bus.ram_own  = ram_own_q;
  assign bus.core_res = core_res_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    addr_d     = addr_q;
    sum_d      = sum_q;
    ram_save_d = 1'b0;
    ram_in_d   = ram_in_q;
    ram_addr_d = ram_addr_q;
    ram_own_d  = ram_own_q;
    core_res_d = core_res_q;
    done_d     = done_q;
    err_d      = err_q;
    case (state_q)
      S_LEN_HI: if (xfer) begin
        len_d   = {bus.in_data, len_q[7:0]};
        state_d = S_LEN_LO;
      end
      S_LEN_LO: if (xfer) begin
        len_d = full_len;
        if (full_len > MAX_LEN) begin
          state_d = S_ERROR;
          err_d   = 1'b1;
        end else if (full_len == 16'd0) begin
          state_d = S_CSUM;
        end else begin
          state_d = S_DATA;
        end
      end
      S_DATA: if (xfer) begin
        // Strobe is registered: the write appears one cycle after the transfer.
        ram_save_d = 1'b1;
        ram_in_d   = bus.in_data;
        ram_addr_d = addr_q;
        addr_d     = addr_q + 16'd1;
        sum_d      = sum_q + bus.in_data;
        len_d      = len_q - 16'd1;
        if (len_q == 16'd1) state_d = S_CSUM;
      end
      S_CSUM: if (xfer) begin
        if (bus.in_data == sum_q) begin
          state_d    = S_RUN;
          ram_own_d  = 1'b0;
          core_res_d = 1'b0;
          done_d     = 1'b1;
        end else begin
          state_d = S_ERROR;
          err_d   = 1'b1;
        end
      end
      S_RUN, S_ERROR: if (bus.load_req) begin
        state_d    = S_LEN_HI;
        len_d      = 16'd0;
        addr_d     = BASE_ADDR;
        sum_d      = 8'd0;
        ram_addr_d = BASE_ADDR;
        ram_own_d  = 1'b1;
        core_res_d = 1'b1;
        done_d     = 1'b0;
        err_d      = 1'b0;
      end
      default: state_d = S_LEN_HI;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      state_q    <= S_LEN_HI;
      len_q      <= 16'd0;
      addr_q     <= BASE_ADDR;
      sum_q      <= 8'd0;
      ram_save_q <= 1'b0;
      ram_in_q   <= 8'd0;
      ram_addr_q <= BASE_ADDR;
      ram_own_q  <= 1'b1;
      core_res_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      sum_q      <= sum_d;
      ram_save_q <= ram_save_d;
      ram_in_q   <= ram_in_d;
      ram_addr_q <= ram_addr_d;
      ram_own_q  <= ram_own_d;
      core_res_q <= core_res_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_goofy_loader.sv
// tb/tb_goofy_loader.sv - self-checking bench for goofy_loader at two base addresses.
module tb_goofy_loader;
  localparam logic [15:0] BASE1 = 16'hFFFE;
  localparam int MAX = 32'h8000;
  localparam int LOADING = 0, OK = 1, BAD = 2;

  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic       in_valid = 1'b0;
  logic       load_req = 1'b0;
  logic [7:0] in_data = 8'h00;
  int tests = 0;
  int fails = 0;

  goofy_loader_if if0 ();
  goofy_loader_if if1 ();
  assign if0.in_valid = in_valid;
  assign if0.in_data  = in_data;
  assign if0.load_req = load_req;
  assign if1.in_valid = in_valid;
  assign if1.in_data  = in_data;
  assign if1.load_req = load_req;

  goofy_loader dut0 (.clk(clk), .res(res), .bus(if0.slave));
  goofy_loader #(.BASE_ADDR(BASE1)) dut1 (.clk(clk), .res(res), .bus(if1.slave));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-position model: where are we in the frame, what has been summed, what must be written.
  int         mode = LOADING;
  int         idx = 0;
  int         mlen = 0;
  logic [7:0] mhi = 8'h00;
  logic [7:0] msum = 8'h00;
  bit         exp_save = 1'b0;
  int         exp_off = 0;
  logic [7:0] exp_data = 8'h00;
  bit         mvalid = 1'b0;
  bit         just_rst = 1'b0;

  always @(posedge clk) begin
    exp_save <= 1'b0;
    just_rst <= 1'b0;
    if (!res) begin
      mode <= LOADING; idx <= 0; msum <= 8'h00; mvalid <= 1'b1; just_rst <= 1'b1;
    end else if (mode != LOADING) begin
      if (load_req) begin mode <= LOADING; idx <= 0; msum <= 8'h00; end
    end else if (in_valid) begin
      if (idx == 0) begin
        mhi <= in_data; idx <= 1;
      end else if (idx == 1) begin
        mlen <= int'({mhi, in_data});
        idx  <= 2;
        if (int'({mhi, in_data}) > MAX) mode <= BAD;
      end else if (idx - 2 < mlen) begin
        exp_save <= 1'b1; exp_off <= idx - 2; exp_data <= in_data;
        msum <= msum + in_data; idx <= idx + 1;
      end else begin
        mode <= (in_data == msum) ? OK : BAD;
      end
    end
  end

  logic [23:0] log0[$];
  logic [23:0] log1[$];

  always @(negedge clk) begin
    if (mvalid) begin
      chk("in_ready0", if0.in_ready, mode == LOADING);
      chk("in_ready1", if1.in_ready, mode == LOADING);
      chk("ram_save0", if0.ram_save, exp_save);
      chk("ram_save1", if1.ram_save, exp_save);
      chk("ram_own0", if0.ram_own, mode != OK);
      chk("ram_own1", if1.ram_own, mode != OK);
      chk("core_res0", if0.core_res, mode != OK);
      chk("core_res1", if1.core_res, mode != OK);
      chk("done0", if0.done, mode == OK);
      chk("done1", if1.done, mode == OK);
      chk("err0", if0.err, mode == BAD);
      chk("err1", if1.err, mode == BAD);
      if (exp_save) begin
        chk("ram_in0", if0.ram_in, exp_data);
        chk("ram_in1", if1.ram_in, exp_data);
        chk("ram_addr0", if0.ram_addr, 16'(exp_off));
        chk("ram_addr1", if1.ram_addr, 16'(BASE1 + 16'(exp_off)));
      end
      if (just_rst) begin
        chk("rst_addr0", if0.ram_addr, 16'h0000);
        chk("rst_addr1", if1.ram_addr, BASE1);
        chk("rst_in0", if0.ram_in, 8'h00);
      end
      if (if0.ram_save === 1'b1) log0.push_back({if0.ram_addr, if0.ram_in});
      if (if1.ram_save === 1'b1) log1.push_back({if1.ram_addr, if1.ram_in});
    end
  end

  task automatic send(input logic [7:0] b, input bit gaps);
    int n;
    n = 0;
    if (gaps) begin
      while (n < 4 && $urandom_range(0, 1) == 1) begin
        in_valid = 1'b0; in_data = 8'($urandom); @(negedge clk); n++;
      end
    end
    in_valid = 1'b1; in_data = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] fr[$], input bit gaps);
    foreach (fr[i]) send(fr[i], gaps);
  endtask

  task automatic pulse_req();
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask

  logic [7:0] fr[$];
  logic [7:0] p[4];
  logic [7:0] s;

  initial begin
    res = 1'b0;
    @(negedge clk);
    chk("rst_ready", if0.in_ready, 1);
    chk("rst_own", if0.ram_own, 1);
    chk("rst_core_res", if0.core_res, 1);
    chk("rst_done", if0.done, 0);
    chk("rst_base1", if1.ram_addr, 16'hFFFE);
    @(negedge clk);
    res = 1'b1;

    // Nominal frame; dut1 also shows the wrap past FFFF.
    log0.delete(); log1.delete();
    fr = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
    send_frame(fr, 1'b0);
    idle(2);
    chk("nom_n", log0.size(), 3);
    chk("nom_w0", log0[0], 24'h0000_11);
    chk("nom_w1", log0[1], 24'h0001_22);
    chk("nom_w2", log0[2], 24'h0002_33);
    chk("nom_wrap2", log1[2], 24'h0000_33);
    chk("nom_done", if0.done, 1);
    chk("nom_core_res", if0.core_res, 0);
    chk("nom_own", if0.ram_own, 0);

    // Bad checksum, then recovery via load_req.
    pulse_req();
    log0.delete(); log1.delete();
    fr = '{8'h00, 8'h02, 8'hAA, 8'h55, 8'h00};
    send_frame(fr, 1'b0);
    idle(1);
    chk("bad_n", log0.size(), 2);
    chk("bad_w1", log0[1], 24'h0001_55);
    chk("bad_err", if0.err, 1);
    chk("bad_ready", if0.in_ready, 0);
    pulse_req();
    chk("req_err", if0.err, 0);
    chk("req_ready", if0.in_ready, 1);

    // Zero-length and oversize frames.
    log0.delete();
    fr = '{8'h00, 8'h00, 8'h00};
    send_frame(fr, 1'b0);
    idle(1);
    chk("zero_done", if0.done, 1);
    chk("zero_n", log0.size(), 0);
    pulse_req();
    send(8'h80, 1'b0);
    send(8'h01, 1'b0);
    chk("over_err", if0.err, 1);
    idle(2);
    chk("over_n", log0.size(), 0);
    pulse_req();

    // Wrap frame at base FFFE.
    log1.delete();
    fr = '{8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'h06};
    send_frame(fr, 1'b0);
    idle(1);
    chk("wrap_w0", log1[0], 24'hFFFE_01);
    chk("wrap_w1", log1[1], 24'hFFFF_02);
    chk("wrap_w2", log1[2], 24'h0000_03);
    chk("wrap_done", if1.done, 1);
    pulse_req();

    // Flow control with an ignored load_req mid-payload.
    log0.delete();
    s = 8'h00;
    foreach (p[i]) begin p[i] = 8'($urandom); s = s + p[i]; end
    send(8'h00, 1'b1); send(8'h04, 1'b1);
    send(p[0], 1'b1); send(p[1], 1'b1);
    pulse_req();
    send(p[2], 1'b1); send(p[3], 1'b1); send(s, 1'b1);
    idle(1);
    chk("flow_n", log0.size(), 4);
    for (int i = 0; i < 4; i++) chk("flow_w", log0[i], {16'(i), p[i]});
    chk("flow_done", if0.done, 1);
    pulse_req();

    // Reset in the middle of a payload.
    fr = '{8'h00, 8'h05, 8'hAB, 8'hCD};
    send_frame(fr, 1'b0);
    res = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready", if0.in_ready, 1);
    chk("mid_rst_addr", if0.ram_addr, 16'h0000);
    chk("mid_rst_done", if0.done, 0);
    res = 1'b1;
    log0.delete();
    fr = '{8'h00, 8'h03, 8'h10, 8'h20, 8'h30, 8'h60};
    send_frame(fr, 1'b1);
    idle(1);
    chk("mid_n", log0.size(), 3);
    chk("mid_w0", log0[0], 24'h0000_10);
    chk("mid_done", if0.done, 1);
    pulse_req();

    // Random frames against the model.
    repeat (10) begin
      int len;
      len = $urandom_range(0, 6);
      fr.delete();
      if ($urandom_range(0, 7) == 0) begin
        fr.push_back(8'h80); fr.push_back(8'h01);
      end else begin
        fr.push_back(8'h00); fr.push_back(8'(len));
        s = 8'h00;
        for (int i = 0; i < len; i++) begin
          fr.push_back(8'($urandom)); s = s + fr[fr.size() - 1];
        end
        if ($urandom_range(0, 3) == 0) s = s ^ 8'h01;
        fr.push_back(s);
      end
      send_frame(fr, 1'b1);
      idle(2);
      pulse_req();
      idle(1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
